// File: rtl/billiard_pkg.sv
// billiard_pkg: shared types, widths and saturating score arithmetic for the shot/turn controller
package billiard_pkg;

    typedef enum logic [2:0] {
        TS_IDLE    = 3'd0,
        TS_AIM     = 3'd1,
        TS_ROLLING = 3'd2,
        TS_RESOLVE = 3'd3,
        TS_OVER    = 3'd4
    } turn_state_t;

    localparam int NUM_BALLS_DEFAULT = 16;
    localparam int VELOCITY_W        = 11;
    localparam int SCORE_W           = 5;
    localparam int SCORE_MAX         = (1 << SCORE_W) - 1;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        return (s > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : s[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/shot_turn_controller_if.sv
// shot_turn_controller_if: aiming, physics and HUD signals of the shot/turn controller
interface shot_turn_controller_if
    import billiard_pkg::*;
#(
    parameter int NUM_BALLS = NUM_BALLS_DEFAULT
);
    logic                         startOfFrame;
    logic                         startGame;
    logic                         velocityWriteEnable;
    logic signed [VELOCITY_W-1:0] newVelocityX;
    logic signed [VELOCITY_W-1:0] newVelocityY;
    logic [NUM_BALLS-1:0]         ballMoving;
    logic [NUM_BALLS-1:0]         ballPocketed;
    logic                         drawLine;
    logic                         shotFired;
    logic                         respotCue;
    logic                         currentPlayer;
    logic [SCORE_W-1:0]           scoreA;
    logic [SCORE_W-1:0]           scoreB;
    logic                         gameOver;

    modport master (
        output startOfFrame, startGame, velocityWriteEnable, newVelocityX, newVelocityY,
               ballMoving, ballPocketed,
        input  drawLine, shotFired, respotCue, currentPlayer, scoreA, scoreB, gameOver
    );

    modport slave (
        input  startOfFrame, startGame, velocityWriteEnable, newVelocityX, newVelocityY,
               ballMoving, ballPocketed,
        output drawLine, shotFired, respotCue, currentPlayer, scoreA, scoreB, gameOver
    );
endinterface

// File: rtl/shot_turn_controller_settle_detector.sv
// settle_detector: counts consecutive motion-free frames while enabled; done at FRAMES
module settle_detector #(
    parameter int FRAMES = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic en,
    input  logic frame,
    input  logic moving,
    output logic done
);
    localparam int W = $clog2(FRAMES + 1);

    logic [W-1:0] cnt;

    assign done = (cnt == W'(FRAMES));

    // any motion or leaving the enabled phase restarts the still-frame run
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            cnt <= '0;
        else
            cnt <= (!en || moving) ? '0 : (frame && !done) ? cnt + W'(1) : cnt;
    end
endmodule

// File: rtl/shot_turn_controller.sv
// shot_turn_controller: aim/roll/score/turn sequencer for one billiard shot; SHOT_TIMEOUT_EN adds an aim forfeit timer
module shot_turn_controller
    import billiard_pkg::*;
#(
    parameter int NUM_BALLS     = NUM_BALLS_DEFAULT,
    parameter int SETTLE_FRAMES = 8,
    parameter int AIM_TIMEOUT   = 600
) (
    input logic                    clk,
    input logic                    resetN,
    shot_turn_controller_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = TS_IDLE;
    localparam logic [2:0] S_AIM     = TS_AIM;
    localparam logic [2:0] S_ROLLING = TS_ROLLING;
    localparam logic [2:0] S_RESOLVE = TS_RESOLVE;
    localparam logic [2:0] S_OVER    = TS_OVER;

    logic [2:0]         state;
    logic [SCORE_W-1:0] pot_cnt;
    logic               cue_foul;
    logic               player;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
    logic               shot;
    logic               respot;
    logic               settled;
    logic               valid_fire;
    logic               aim_expired;
    logic [SCORE_W-1:0] new_a;
    logic [SCORE_W-1:0] new_b;
    logic               pass_turn;
    logic               all_potted;

    assign valid_fire = bus.velocityWriteEnable && (bus.newVelocityX != '0 || bus.newVelocityY != '0);
    assign new_a      = player ? score_a : sat_add(score_a, int'(pot_cnt));
    assign new_b      = player ? sat_add(score_b, int'(pot_cnt)) : score_b;
    assign pass_turn  = (pot_cnt == '0) || cue_foul;
    assign all_potted = (int'(new_a) + int'(new_b)) >= NUM_BALLS - 1;

    settle_detector #(.FRAMES(SETTLE_FRAMES)) u_settle (
        .clk    (clk),
        .resetN (resetN),
        .en     (state == S_ROLLING),
        .frame  (bus.startOfFrame),
        .moving (|bus.ballMoving),
        .done   (settled)
    );

`ifdef SHOT_TIMEOUT_EN
    localparam int AW = $clog2(AIM_TIMEOUT + 1);

    logic [AW-1:0] aim_cnt;

    assign aim_expired = (state == S_AIM) && !valid_fire && bus.startOfFrame && aim_cnt == AW'(AIM_TIMEOUT - 1);

    // aim frame timer restarts whenever AIM is entered, a shot is taken or the turn is forfeited
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            aim_cnt <= '0;
        else
            aim_cnt <= (state != S_AIM || valid_fire || aim_expired) ? '0 : aim_cnt + AW'(bus.startOfFrame);
    end
`else
    assign aim_expired = 1'b0;
`endif

    // game-flow sequencing, pocket accounting and score/turn resolution
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= S_IDLE;
            pot_cnt  <= '0;
            cue_foul <= 1'b0;
            player   <= 1'b0;
            score_a  <= '0;
            score_b  <= '0;
            shot     <= 1'b0;
            respot   <= 1'b0;
        end else begin
            shot   <= 1'b0;
            respot <= 1'b0;
            case (state)
                S_IDLE, S_OVER: if (bus.startGame) begin
                    state   <= S_AIM;
                    score_a <= '0;
                    score_b <= '0;
                    player  <= 1'b0;
                end
                S_AIM: if (valid_fire) begin
                    shot  <= 1'b1;
                    state <= S_ROLLING;
                end else if (aim_expired) begin
                    player <= ~player;
                end
                S_ROLLING: begin
                    pot_cnt  <= sat_add(pot_cnt, $countones(bus.ballPocketed[NUM_BALLS-1:1]));
                    cue_foul <= cue_foul | bus.ballPocketed[0];
                    if (settled)
                        state <= S_RESOLVE;
                end
                S_RESOLVE: begin
                    score_a  <= new_a;
                    score_b  <= new_b;
                    player   <= player ^ pass_turn;
                    respot   <= cue_foul;
                    pot_cnt  <= '0;
                    cue_foul <= 1'b0;
                    state    <= all_potted ? S_OVER : S_AIM;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.drawLine      = (state == S_AIM);
    assign bus.gameOver      = (state == S_OVER);
    assign bus.shotFired     = shot;
    assign bus.respotCue     = respot;
    assign bus.currentPlayer = player;
    assign bus.scoreA        = score_a;
    assign bus.scoreB        = score_b;
endmodule

// File: tb/tb_shot_turn_controller.sv
// tb_shot_turn_controller: directed shots against a frame-level game model plus literal checkpoints
module tb_shot_turn_controller;
    import billiard_pkg::*;

    localparam int NB = 16;
    localparam int SF = 8;
    localparam int AT = 4;
`ifdef SHOT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    shot_turn_controller_if #(.NUM_BALLS(NB)) bus ();

    shot_turn_controller #(.NUM_BALLS(NB), .SETTLE_FRAMES(SF), .AIM_TIMEOUT(AT)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: phase 0 idle, 1 aiming, 2 balls rolling, 3 scoring, 4 game over
    int m_phase, m_pot, m_still, m_aim, m_sa, m_sb, na, nb;
    bit m_foul, m_player, m_shot, m_respot;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_phase <= 0; m_pot <= 0; m_still <= 0; m_aim <= 0; m_sa <= 0; m_sb <= 0;
            m_foul <= 0; m_player <= 0; m_shot <= 0; m_respot <= 0;
        end else begin
            m_shot <= 0;
            m_respot <= 0;
            if (m_phase != 1) m_aim <= 0;
            if ((m_phase == 0 || m_phase == 4) && bus.startGame) begin
                m_phase <= 1; m_sa <= 0; m_sb <= 0; m_player <= 0;
            end else if (m_phase == 1) begin
                if (bus.velocityWriteEnable && (bus.newVelocityX != 0 || bus.newVelocityY != 0)) begin
                    m_shot <= 1; m_phase <= 2; m_aim <= 0;
                end else if (TO_EN && bus.startOfFrame) begin
                    if (m_aim + 1 == AT) begin m_player <= !m_player; m_aim <= 0; end
                    else m_aim <= m_aim + 1;
                end
            end else if (m_phase == 2) begin
                m_pot  <= m_pot + $countones(bus.ballPocketed[NB-1:1]);
                m_foul <= m_foul | bus.ballPocketed[0];
                if (m_still == SF) begin m_phase <= 3; m_still <= 0; end
                else if (bus.ballMoving != 0) m_still <= 0;
                else if (bus.startOfFrame) m_still <= m_still + 1;
            end else if (m_phase == 3) begin
                na = m_player ? m_sa : ((m_sa + m_pot > 31) ? 31 : m_sa + m_pot);
                nb = m_player ? ((m_sb + m_pot > 31) ? 31 : m_sb + m_pot) : m_sb;
                m_sa <= na;
                m_sb <= nb;
                m_player <= m_player ^ (m_pot == 0 || m_foul);
                m_respot <= m_foul;
                m_pot <= 0;
                m_foul <= 0;
                m_phase <= (na + nb >= NB - 1) ? 4 : 1;
            end
        end
    end

    logic [14:0] act_v, exp_v;
    assign act_v = {bus.drawLine, bus.shotFired, bus.respotCue, bus.currentPlayer, bus.scoreA, bus.scoreB, bus.gameOver};
    assign exp_v = {m_phase == 1, m_shot, m_respot, m_player, m_sa[4:0], m_sb[4:0], m_phase == 4};

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) check("cycle_outputs", int'(act_v), int'(exp_v));

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic fire(input logic signed [10:0] x, input logic signed [10:0] y);
        bus.newVelocityX = x;
        bus.newVelocityY = y;
        bus.velocityWriteEnable = 1'b1;
        cyc();
        bus.velocityWriteEnable = 1'b0;
    endtask

    task automatic frames(input int n, input logic [15:0] mv);
        bus.ballMoving = mv;
        repeat (n) begin
            bus.startOfFrame = 1'b1;
            cyc();
        end
        bus.startOfFrame = 1'b0;
    endtask

    task automatic pocket(input logic [15:0] m);
        bus.ballPocketed = m;
        cyc();
        bus.ballPocketed = '0;
    endtask

    task automatic start_game();
        bus.startGame = 1'b1;
        cyc();
        bus.startGame = 1'b0;
    endtask

    task automatic wait_turn(output int respots);
        respots = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (bus.respotCue) respots++;
            if (bus.drawLine || bus.gameOver) return;
        end
        check("turn_end_timeout", 0, 1);
    endtask

    int r;

    initial begin
        bus.startOfFrame = 0; bus.startGame = 0; bus.velocityWriteEnable = 0;
        bus.newVelocityX = '0; bus.newVelocityY = '0; bus.ballMoving = '0; bus.ballPocketed = '0;
        repeat (3) cyc();
        check("reset_outputs", int'(act_v), 0);
        resetN = 1'b1;
        cyc();
        start_game();
        check("start_draw", int'(bus.drawLine), 1);
        check("start_player", int'(bus.currentPlayer), 0);
        check("start_scores", int'(bus.scoreA) + int'(bus.scoreB), 0);

        fire(11'sd5, -11'sd3);
        check("shot_pulse", int'(bus.shotFired), 1);
        check("roll_draw_off", int'(bus.drawLine), 0);
        cyc();
        check("shot_single", int'(bus.shotFired), 0);
        frames(20, 16'h0006);
        frames(7, 16'h0000);
        repeat (3) cyc();
        check("seven_still_player", int'(bus.currentPlayer), 0);
        check("seven_still_rolling", int'(bus.drawLine), 0);
        frames(1, 16'h0000);
        wait_turn(r);
        check("miss_player", int'(bus.currentPlayer), 1);
        check("miss_scoreA", int'(bus.scoreA), 0);
        check("miss_respot", r, 0);

        resetN = 1'b0;
        cyc();
        resetN = 1'b1;
        cyc();
        start_game();
        fire(11'sd10, 11'sd0);
        bus.ballMoving = 16'h0001;
        pocket(16'h0088);
        frames(8, 16'h0000);
        wait_turn(r);
        check("pot2_scoreA", int'(bus.scoreA), 2);
        check("pot2_player", int'(bus.currentPlayer), 0);
        check("pot2_draw", int'(bus.drawLine), 1);

        fire(-11'sd4, 11'sd7);
        pocket(16'h0021);
        frames(8, 16'h0000);
        wait_turn(r);
        check("foul_scoreA", int'(bus.scoreA), 3);
        check("foul_respot", r, 1);
        check("foul_player", int'(bus.currentPlayer), 1);
        cyc();
        check("respot_single", int'(bus.respotCue), 0);

        pocket(16'h0200);
        fire(11'sd1, 11'sd1);
        pocket(16'h0004);
        frames(8, 16'h0000);
        wait_turn(r);
        check("b_scoreB", int'(bus.scoreB), 1);
        check("b_keeps_turn", int'(bus.currentPlayer), 1);
        check("aim_pocket_ignored_scoreA", int'(bus.scoreA), 3);

        fire(11'sd2, 11'sd2);
        pocket(16'hFFE0);
        frames(8, 16'h0000);
        wait_turn(r);
        check("over_flag", int'(bus.gameOver), 1);
        check("over_scoreB", int'(bus.scoreB), 12);
        check("over_draw", int'(bus.drawLine), 0);
        start_game();
        check("restart_draw", int'(bus.drawLine), 1);
        check("restart_scores", int'(bus.scoreA) + int'(bus.scoreB), 0);
        check("restart_over", int'(bus.gameOver), 0);

        fire(11'sd3, 11'sd0);
        pocket(16'hFFFE);
        pocket(16'hFFFE);
        start_game();
        check("start_ignored_rolling", int'(bus.drawLine), 0);
        pocket(16'hFFFE);
        frames(8, 16'h0000);
        wait_turn(r);
        check("sat_scoreA", int'(bus.scoreA), 31);
        check("sat_over", int'(bus.gameOver), 1);
        start_game();

        fire(11'sd1, 11'sd0);
        pocket(16'h0010);
        frames(8, 16'h0000);
        wait_turn(r);
        check("pre_reset_scoreA", int'(bus.scoreA), 1);
        bus.newVelocityX = '0;
        bus.newVelocityY = '0;
        bus.velocityWriteEnable = 1'b1;
        cyc();
        bus.velocityWriteEnable = 1'b0;
        check("zero_fire_no_shot", int'(bus.shotFired), 0);
        check("zero_fire_aim", int'(bus.drawLine), 1);
        frames(AT, 16'h0000);
        cyc();
`ifdef SHOT_TIMEOUT_EN
        check("timeout_player", int'(bus.currentPlayer), 1);
`else
        check("no_timeout_player", int'(bus.currentPlayer), 0);
`endif
        check("timeout_draw", int'(bus.drawLine), 1);

        fire(11'sd5, -11'sd3);
        frames(3, 16'h0001);
        resetN = 1'b0;
        #1;
        check("async_reset_outputs", int'(act_v), 0);
        cyc();
        cyc();
        resetN = 1'b1;
        repeat (3) cyc();
        check("post_reset_idle", int'(act_v), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
